// File: rtl/vga_rx_capture_if.sv
// Sync/RGB pins of a VGA link plus the recovered pixel stream and lock status.
// master drives the pins and observes the stream; slave is the capture block.
interface vga_rx_capture_if;
  logic       hsync;
  logic       vsync;
  logic       red;
  logic       green;
  logic       blue;
  logic       px_valid;
  logic [9:0] px_x;
  logic [9:0] px_y;
  logic [2:0] px_rgb;
  logic       frame_start;
  logic       locked;
  logic       line_err;
  logic       frame_err;
  logic [7:0] err_count;

  modport master (
    output hsync, vsync, red, green, blue,
    input  px_valid, px_x, px_y, px_rgb, frame_start, locked, line_err, frame_err, err_count
  );

  modport slave (
    input  hsync, vsync, red, green, blue,
    output px_valid, px_x, px_y, px_rgb, frame_start, locked, line_err, frame_err, err_count
  );
endinterface

// File: rtl/vga_rx_capture.sv
// VGA receiver: recovers pixel coordinates from hsync/vsync, checks line and frame
// timing against the expected mode, and emits a gated pixel stream with lock status.
module vga_rx_capture #(
  parameter int unsigned HRES        = 640,
  parameter int unsigned HF          = 16,
  parameter int unsigned HS          = 96,
  parameter int unsigned HB          = 48,
  parameter int unsigned VRES        = 480,
  parameter int unsigned VF          = 10,
  parameter int unsigned VS          = 2,
  parameter int unsigned VB          = 33,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic              clk,
  input logic              reset,
  vga_rx_capture_if.slave  vga
);

  localparam logic [9:0] CntMax    = 10'd1023;
  localparam logic [9:0] HsLen     = 10'(HS);
  localparam logic [9:0] HLast     = 10'(HS + HF + HB + HRES - 1);
  localparam logic [9:0] HActFirst = 10'(HS + HB);
  localparam logic [9:0] HActLast  = 10'(HS + HB + HRES - 1);
  localparam logic [9:0] VsLen     = 10'(VS);
  localparam logic [9:0] VLast     = 10'(VS + VF + VB + VRES - 1);
  localparam logic [9:0] VActFirst = 10'(VS + VB - 1);
  localparam logic [9:0] VActLast  = 10'(VS + VB + VRES - 2);
  localparam logic [7:0] LockLast  = 8'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {StSearch, StTrain, StLocked} state_e;

  // Input sample stage and edge-detect history
  logic       hs_q, hs_d, hs_prev_q, hs_prev_d;
  logic       vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic [2:0] rgb_in_q, rgb_in_d;

  // Timing recovery
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic [9:0] vs_cnt_q, vs_cnt_d;
  logic       arm_q, arm_d;

  // Lock tracking
  state_e     state_q, state_d;
  logic [7:0] good_q, good_d;
  logic       frame_bad_q, frame_bad_d;

  // Registered outputs
  logic       px_valid_q, px_valid_d;
  logic [9:0] px_x_q, px_x_d;
  logic [9:0] px_y_q, px_y_d;
  logic [2:0] px_rgb_q, px_rgb_d;
  logic       frame_start_q, frame_start_d;
  logic       line_err_q, line_err_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] err_count_q, err_count_d;

  logic       hs_fall, hs_rise, vs_fall, vs_rise;
  logic       line_bad, frame_bad_now, err_any;
  logic       h_act, v_act;
  logic [8:0] err_sum;

  always_comb begin
    hs_d      = vga.hsync;
    vs_d      = vga.vsync;
    rgb_in_d  = {vga.red, vga.green, vga.blue};
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;

    hs_fall = hs_prev_q & ~hs_q;
    hs_rise = ~hs_prev_q & hs_q;
    vs_fall = vs_prev_q & ~vs_q;
    vs_rise = ~vs_prev_q & vs_q;

    // hc_d/vc_d are the coordinates of the sample currently held in hs_q/rgb_in_q
    if (hs_fall) begin
      hc_d = '0;
    end else if (hc_q == CntMax) begin
      hc_d = CntMax;
    end else begin
      hc_d = hc_q + 10'd1;
    end

    vc_d = vc_q;
    if (hs_fall) begin
      if (arm_q || vs_fall) begin
        vc_d = '0;
      end else if (vc_q != CntMax) begin
        vc_d = vc_q + 10'd1;
      end
    end
    arm_d = (arm_q | vs_fall) & ~hs_fall;

    // Number of hsync falling edges seen while vsync is low
    vs_cnt_d = vs_cnt_q;
    if (vs_fall) begin
      vs_cnt_d = hs_fall ? 10'd1 : 10'd0;
    end else if (!vs_q && hs_fall && vs_cnt_q != CntMax) begin
      vs_cnt_d = vs_cnt_q + 10'd1;
    end

    line_bad = (hs_rise && hc_d != HsLen) ||
               (hs_fall && hc_q != HLast) ||
               (hc_d == CntMax && hc_q != CntMax);
    frame_bad_now = (vs_fall && vc_q != VLast) || (vs_rise && vs_cnt_q != VsLen);

    line_err_d  = line_bad && (state_q != StSearch);
    frame_err_d = frame_bad_now && (state_q != StSearch);
    err_any     = line_err_d | frame_err_d;

    err_sum     = {1'b0, err_count_q} + {8'b0, line_err_d} + {8'b0, frame_err_d};
    err_count_d = err_sum[8] ? 8'hff : err_sum[7:0];

    state_d     = state_q;
    good_d      = good_q;
    frame_bad_d = frame_bad_q;
    case (state_q)
      StSearch: begin
        if (vs_fall) begin
          state_d     = StTrain;
          good_d      = '0;
          frame_bad_d = 1'b0;
        end
      end
      StTrain: begin
        // A frame counts as good only if nothing went wrong from arm to arm
        if (vs_fall) begin
          frame_bad_d = 1'b0;
          if (frame_bad_q || err_any) begin
            good_d = '0;
          end else if (good_q >= LockLast) begin
            state_d = StLocked;
            good_d  = '0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end else if (err_any) begin
          good_d      = '0;
          frame_bad_d = 1'b1;
        end
      end
      StLocked: begin
        if (err_any) begin
          state_d = StSearch;
        end
      end
      default: state_d = StSearch;
    endcase

    h_act = (hc_d >= HActFirst) && (hc_d <= HActLast);
    v_act = (vc_d >= VActFirst) && (vc_d <= VActLast);

    px_valid_d    = (state_d == StLocked) && h_act && v_act;
    px_x_d        = px_valid_d ? (hc_d - HActFirst) : px_x_q;
    px_y_d        = px_valid_d ? (vc_d - VActFirst) : px_y_q;
    px_rgb_d      = px_valid_d ? rgb_in_q : px_rgb_q;
    frame_start_d = px_valid_d && (hc_d == HActFirst) && (vc_d == VActFirst);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q          <= 1'b1;
      hs_prev_q     <= 1'b1;
      vs_q          <= 1'b1;
      vs_prev_q     <= 1'b1;
      rgb_in_q      <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      vs_cnt_q      <= '0;
      arm_q         <= 1'b0;
      state_q       <= StSearch;
      good_q        <= '0;
      frame_bad_q   <= 1'b0;
      px_valid_q    <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      px_rgb_q      <= '0;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      hs_q          <= hs_d;
      hs_prev_q     <= hs_prev_d;
      vs_q          <= vs_d;
      vs_prev_q     <= vs_prev_d;
      rgb_in_q      <= rgb_in_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      vs_cnt_q      <= vs_cnt_d;
      arm_q         <= arm_d;
      state_q       <= state_d;
      good_q        <= good_d;
      frame_bad_q   <= frame_bad_d;
      px_valid_q    <= px_valid_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      px_rgb_q      <= px_rgb_d;
      frame_start_q <= frame_start_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign vga.px_valid    = px_valid_q;
  assign vga.px_x        = px_x_q;
  assign vga.px_y        = px_y_q;
  assign vga.px_rgb      = px_rgb_q;
  assign vga.frame_start = frame_start_q;
  assign vga.locked      = (state_q == StLocked);
  assign vga.line_err    = line_err_q;
  assign vga.frame_err   = frame_err_q;
  assign vga.err_count   = err_count_q;

endmodule

// File: tb/tb_vga_rx_capture.sv
// Directed bench for vga_rx_capture on a shrunken video mode (15 clocks x 9 lines)
// driven by a small sync/pattern generator; pixel rgb = x[2:0] ^ y[2:0].
module tb_vga_rx_capture;
  localparam int HRES = 8;
  localparam int HF   = 2;
  localparam int HS   = 3;
  localparam int HB   = 2;
  localparam int VRES = 4;
  localparam int VF   = 1;
  localparam int VS   = 2;
  localparam int VB   = 2;
  localparam int HTOT = HS + HF + HB + HRES;
  localparam int VTOT = VS + VF + VB + VRES;
  localparam int HOFF = HS + HB;
  localparam int VOFF = VS + VB - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_rx_capture_if vif ();

  vga_rx_capture #(
    .HRES(HRES), .HF(HF), .HS(HS), .HB(HB),
    .VRES(VRES), .VF(VF), .VS(VS), .VB(VB), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vga(vif)
  );

  int total, bad;
  int gh, gl;
  bit long_pending, vs3, stuck;
  bit p_win;
  int p_x, p_y;
  logic [2:0] p_rgb;
  int vcnt, oob, pat_bad, fs_cnt, fs_bad, le_cnt, fe_cnt, drops, drops_err;
  logic [4:0] corners;
  logic prev_locked;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    vcnt = 0; oob = 0; pat_bad = 0; fs_cnt = 0; fs_bad = 0;
    le_cnt = 0; fe_cnt = 0; drops = 0; drops_err = 0; corners = '0;
  endtask

  // Drive one pixel, clock it in, then score the outputs of the previous pixel
  task automatic step();
    int lim, x, y;
    bit win;
    logic [2:0] rgb;
    win = (gh >= HOFF) && (gh < HOFF + HRES) && (gl >= VOFF) && (gl < VOFF + VRES);
    x   = gh - HOFF;
    y   = gl - VOFF;
    rgb = win ? 3'(x[2:0] ^ y[2:0]) : 3'b000;
    vif.hsync = stuck ? 1'b1 : (gh >= HS);
    vif.vsync = stuck ? 1'b1 : (gl >= (vs3 ? 3 : VS));
    {vif.red, vif.green, vif.blue} = rgb;
    @(posedge clk);
    #1;
    if (vif.px_valid) begin
      vcnt++;
      if (!p_win) oob++;
      if (vif.px_x !== 10'(p_x) || vif.px_y !== 10'(p_y) || vif.px_rgb !== p_rgb) begin
        pat_bad++;
      end else begin
        if (p_x == 0 && p_y == 0) corners[0] = 1'b1;
        if (p_x == HRES - 1 && p_y == 0) corners[1] = 1'b1;
        if (p_x == 0 && p_y == VRES - 1) corners[2] = 1'b1;
        if (p_x == HRES - 1 && p_y == VRES - 1) corners[3] = 1'b1;
        if (p_x == HRES / 2 && p_y == VRES / 2) corners[4] = 1'b1;
      end
    end
    if (vif.frame_start) begin
      fs_cnt++;
      if (!vif.px_valid || vif.px_x != 10'd0 || vif.px_y != 10'd0) fs_bad++;
    end
    if (vif.line_err) le_cnt++;
    if (vif.frame_err) fe_cnt++;
    if (prev_locked && !vif.locked) begin
      drops++;
      if (vif.line_err || vif.frame_err) drops_err++;
    end
    prev_locked = vif.locked;
    p_win = win; p_x = x; p_y = y; p_rgb = rgb;
    lim = (long_pending && gl == 4) ? HTOT + 1 : HTOT;
    gh++;
    if (gh >= lim) begin
      gh = 0;
      if (lim != HTOT) long_pending = 1'b0;
      gl = (gl == VTOT - 1) ? 0 : gl + 1;
    end
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      do step(); while (!(gh == 0 && gl == 0));
    end
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0;
    gh = 0; gl = 0;
    long_pending = 1'b0; vs3 = 1'b0; stuck = 1'b0;
    p_win = 1'b0; p_x = 0; p_y = 0; p_rgb = '0;
    prev_locked = 1'b0;
    clear_stats();
    reset = 1'b1;
    vif.hsync = 1'b1; vif.vsync = 1'b1;
    vif.red = 1'b0; vif.green = 1'b0; vif.blue = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_px", 32'({vif.px_valid, vif.px_x, vif.px_y, vif.px_rgb}), 0);
    check("rst_flags", 32'({vif.frame_start, vif.locked, vif.line_err, vif.frame_err,
                            vif.err_count}), 0);
    #2 reset = 1'b0;

    // Nominal stream: lock at the arm that closes the 2nd good frame
    run_frames(2);
    check("train_unlocked", 32'(vif.locked), 0);
    step();
    check("lock_not_yet", 32'(vif.locked), 0);
    step();
    check("lock_rise", 32'(vif.locked), 1);
    clear_stats();
    run_frames(2);
    check("valid_cnt", vcnt, 2 * HRES * VRES);
    check("valid_oob", oob, 0);
    check("pattern", pat_bad, 0);
    check("fs_cnt", fs_cnt, 2);
    check("fs_pos", fs_bad, 0);
    check("corners", 32'(corners), 32'h1f);
    check("nominal_errs", le_cnt + fe_cnt, 0);
    check("lock_hold", 32'(vif.locked), 1);

    // One line stretched by a clock
    clear_stats();
    long_pending = 1'b1;
    run_frames(1);
    check("long_le", le_cnt, 1);
    check("long_fe", fe_cnt, 0);
    check("long_unlock", 32'(vif.locked), 0);
    check("long_drop_same_cycle", drops_err, 1);
    check("long_drops", drops, 1);
    check("long_errcnt", 32'(vif.err_count), 1);
    check("long_valid_partial", vcnt, 2 * HRES);

    clear_stats();
    run_frames(2);
    check("relock_wait", 32'(vif.locked), 0);
    run_frames(1);
    check("relock", 32'(vif.locked), 1);
    check("relock_valid", vcnt, HRES * VRES);
    check("relock_errs", le_cnt + fe_cnt, 0);
    check("relock_errcnt", 32'(vif.err_count), 1);

    // vsync held low for 3 lines
    clear_stats();
    vs3 = 1'b1;
    run_frames(1);
    vs3 = 1'b0;
    check("vs3_fe", fe_cnt, 1);
    check("vs3_le", le_cnt, 0);
    check("vs3_unlock", 32'(vif.locked), 0);
    check("vs3_drop_same_cycle", drops_err, 1);
    check("vs3_errcnt", 32'(vif.err_count), 2);
    check("vs3_valid", vcnt, 0);
    run_frames(3);
    check("vs3_relock", 32'(vif.locked), 1);

    // hsync (and vsync) stuck high until hc saturates
    clear_stats();
    stuck = 1'b1;
    run_steps(1100);
    check("stuck_le", le_cnt, 1);
    check("stuck_fe", fe_cnt, 0);
    check("stuck_unlock", 32'(vif.locked), 0);
    check("stuck_valid", vcnt, 0);
    check("stuck_errcnt", 32'(vif.err_count), 3);
    stuck = 1'b0;

    // Asynchronous reset in the middle of an active line
    run_frames(4);
    while (!(gl == 4 && gh == 7)) step();
    check("pre_rst_locked", 32'(vif.locked), 1);
    check("pre_rst_valid", 32'(vif.px_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_px", 32'({vif.px_valid, vif.px_x, vif.px_y, vif.px_rgb}), 0);
    check("rst_mid_flags", 32'({vif.frame_start, vif.locked, vif.line_err, vif.frame_err,
                                vif.err_count}), 0);
    #2 reset = 1'b0;
    prev_locked = 1'b0;
    clear_stats();
    run_frames(1);
    run_frames(2);
    check("post_rst_wait", 32'(vif.locked), 0);
    step();
    step();
    check("post_rst_relock", 32'(vif.locked), 1);
    check("post_rst_errcnt", 32'(vif.err_count), 0);
    check("post_rst_errs", le_cnt + fe_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
